// File: rtl/uart_alu_interface.sv
// Glue between UART RX, a combinational ALU and UART TX: gathers A, B and the
// opcode, captures the ALU result and requests one transmit per operation.
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun,
    output logic [2:0]         o_state
);

    // Handshake: i_rx_done_tick / i_tx_done_tick are single-cycle strobes with
    // no back-pressure; a byte arriving while busy is lost and flagged.
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   load_a;
    logic   load_b;
    logic   load_op;
    logic   load_tx;
    logic   drop;

    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;
        load_tx = 1'b0;
        drop    = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done_tick) begin
                    load_a  = 1'b1;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done_tick) begin
                    load_b  = 1'b1;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_done_tick) begin
                    load_op = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                load_tx = 1'b1;
                drop    = i_rx_done_tick;
                state_d = SEND;
            end
            SEND: begin
                drop    = i_rx_done_tick;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                drop = i_rx_done_tick;
                if (i_tx_done_tick) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= WAIT_A;
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_op      <= '0;
            o_tx_data <= '0;
            o_overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_a)  o_data_a  <= i_rx_data;
            if (load_b)  o_data_b  <= i_rx_data;
            if (load_op) o_op      <= i_rx_data[NB_OP-1:0];
            if (load_tx) o_tx_data <= i_alu_result;
            if (drop)    o_overrun <= 1'b1;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign o_tx_start = (state_q == SEND);
    assign o_busy     = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);
    assign o_state    = state_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: directed scenarios then randomized operations,
// each result predicted from the bytes sent and a behavioural ALU.
module tb_uart_alu_interface;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done_tick = 1'b0;
    logic [7:0] i_alu_result;
    logic       i_tx_done_tick = 1'b0;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_overrun;
    logic [2:0] o_state;

    int         checks = 0;
    int         passes = 0;
    int         pulses = 0;
    logic [7:0] exp_q[$];
    logic       exp_overrun = 1'b0;
    logic [7:0] last_res = 8'h00;

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_rx_data      (i_rx_data),
        .i_rx_done_tick (i_rx_done_tick),
        .i_alu_result   (i_alu_result),
        .i_tx_done_tick (i_tx_done_tick),
        .o_data_a       (o_data_a),
        .o_data_b       (o_data_b),
        .o_op           (o_op),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun),
        .o_state        (o_state)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // Behavioural ALU: used both as the environment's ALU and as the predictor.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_model(o_data_a, o_data_b, o_op);

    always @(posedge i_clk) begin
        if (o_tx_start === 1'b1) pulses <= pulses + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        tick();
        i_rx_done_tick = 1'b0;
        i_rx_data      = 8'($urandom);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int gap);
        logic [7:0] res;
        res = alu_model(a, b, opb[5:0]);
        send_byte(a);
        check("a_latched", o_data_a, a);
        idle(gap);
        send_byte(b);
        check("b_latched", o_data_b, b);
        idle(gap);
        send_byte(opb);
        exp_q.push_back(res);
        check("op_exec", 8'(o_op), {2'b00, opb[5:0]});
        check("busy_exec", 8'(o_busy), 8'd1);
        check("start_exec", 8'(o_tx_start), 8'd0);
        tick();
        check("start_send", 8'(o_tx_start), 8'd1);
        check("tx_data", o_tx_data, exp_q.pop_front());
        last_res = res;
        tick();
        check("start_after", 8'(o_tx_start), 8'd0);
        check("busy_wait_tx", 8'(o_busy), 8'd1);
    endtask

    task automatic finish_tx(input int wait_cycles, input bit junk);
        int p0;
        p0 = pulses;
        idle(wait_cycles);
        if (junk) begin
            send_byte(8'h7F);
            exp_overrun = 1'b1;
            check("overrun_set", 8'(o_overrun), 8'd1);
            check("busy_after_drop", 8'(o_busy), 8'd1);
            check("tx_data_held", o_tx_data, last_res);
            idle(2);
        end
        i_tx_done_tick = 1'b1;
        tick();
        i_tx_done_tick = 1'b0;
        check("busy_idle", 8'(o_busy), 8'd0);
        check("overrun_flag", 8'(o_overrun), 8'(exp_overrun));
        check("tx_data_stable", o_tx_data, last_res);
        check("no_extra_start", 8'(pulses - p0), 8'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, o_data_a, 8'h00);
        check({tag, "_b"}, o_data_b, 8'h00);
        check({tag, "_op"}, 8'(o_op), 8'h00);
        check({tag, "_tx_data"}, o_tx_data, 8'h00);
        check({tag, "_start"}, 8'(o_tx_start), 8'd0);
        check({tag, "_busy"}, 8'(o_busy), 8'd0);
        check({tag, "_overrun"}, 8'(o_overrun), 8'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [5:0] op_tab[6];
        int p0;
        op_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h02};

        #2 i_reset_n = 1'b0;
        #1 check_all_zero("reset");
        idle(2);
        i_reset_n = 1'b1;
        tick();

        // add with a long transmit
        run_op(8'h05, 8'h03, 8'h20, 2);
        finish_tx(50, 1'b0);

        // opcode truncation: 0xE2 -> 0x22 (subtract)
        run_op(8'h11, 8'h22, 8'hE2, 1);
        finish_tx(5, 1'b0);

        // byte dropped while waiting on the transmitter
        run_op(8'h40, 8'h02, 8'h24, 0);
        finish_tx(10, 1'b1);
        run_op(8'h01, 8'h01, 8'h20, 0);
        check("add_1_1", last_res, 8'h02);
        finish_tx(3, 1'b0);

        // asynchronous reset mid-way through WAIT_OP
        send_byte(8'h33);
        send_byte(8'h44);
        #3 i_reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_overrun = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();
        run_op(8'h0A, 8'h04, 8'h22, 0);
        finish_tx(4, 1'b0);

        // rx and tx done in the same WAIT_TX cycle
        run_op(8'h10, 8'h20, 8'h25, 0);
        idle(3);
        i_rx_data      = 8'h99;
        i_rx_done_tick = 1'b1;
        i_tx_done_tick = 1'b1;
        tick();
        i_rx_done_tick = 1'b0;
        i_tx_done_tick = 1'b0;
        exp_overrun = 1'b1;
        check("simul_busy", 8'(o_busy), 8'd0);
        check("simul_overrun", 8'(o_overrun), 8'd1);
        check("simul_a_kept", o_data_a, 8'h10);
        run_op(8'h5A, 8'h0F, 8'h26, 0);
        finish_tx(2, 1'b0);

        // back-to-back operations with consecutive byte ticks
        p0 = pulses;
        run_op(8'hC8, 8'h64, 8'h20, 0);
        finish_tx(1, 1'b0);
        run_op(8'h03, 8'h09, 8'h22, 0);
        finish_tx(1, 1'b0);
        check("b2b_pulses", 8'(pulses - p0), 8'd2);

        // randomized operations
        for (int i = 0; i < 12; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [7:0] rop;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = {2'($urandom_range(0, 3)), op_tab[$urandom_range(0, 5)]};
            run_op(ra, rb, rop, $urandom_range(0, 3));
            finish_tx($urandom_range(1, 20), 1'($urandom_range(0, 1)));
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
